// File: rtl/minimicro_fetch_unit.sv
// Instruction-fetch front end: PC generator, credit-limited memory requests and a prefetch FIFO to decode.
// Branch redirects flush the FIFO and silently drop responses still in flight for the old path.
module minimicro_fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int RESET_PC    = 0,
  parameter int PC_STEP     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             imem_req,
  output logic [PC_WIDTH-1:0]              imem_addr,
  input  logic                             imem_gnt,
  input  logic                             imem_rvalid,
  input  logic [INSTR_WIDTH-1:0]           imem_rdata,
  input  logic                             branch_valid,
  input  logic [PC_WIDTH-1:0]              branch_target,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  output logic [INSTR_WIDTH-1:0]           instr_data,
  output logic [PC_WIDTH-1:0]              instr_pc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             proto_err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  logic [1:0]             state;
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    resp_pc;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          outstanding_next;
  logic [CW-1:0]          discard;
  logic [CW-1:0]          discard_next;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [INSTR_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    mem_pc   [FIFO_DEPTH];
  logic                   credit_ok;
  logic                   grant;
  logic                   resp_ok;
  logic                   push;
  logic                   pop;

  assign imem_addr   = fetch_pc;
  assign instr_valid = (fifo_count != '0) && !branch_valid;
  assign instr_data  = mem_data[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];

  // Outstanding requests reserve FIFO slots, so a response always has room to land.
  always_comb begin
    credit_ok        = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH);
    imem_req         = (state != S_BOOT) && !branch_valid && credit_ok;
    grant            = imem_req && imem_gnt;
    resp_ok          = imem_rvalid && (outstanding != '0);
    push             = resp_ok && !branch_valid && (discard == '0);
    pop              = instr_valid && instr_ready;
    outstanding_next = outstanding + CW'(grant) - CW'(resp_ok);
    discard_next     = discard;
    if (branch_valid)
      discard_next = outstanding_next;
    else if (resp_ok && (discard != '0))
      discard_next = discard - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      fetch_pc    <= PC_WIDTH'(RESET_PC);
      resp_pc     <= PC_WIDTH'(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      proto_err   <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (imem_rvalid && (outstanding == '0))
        proto_err <= 1'b1;
      if (branch_valid) begin
        fetch_pc   <= branch_target;
        resp_pc    <= branch_target;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
        state      <= (outstanding_next != '0) ? S_DRAIN : S_RUN;
      end else begin
        if (grant)
          fetch_pc <= fetch_pc + STEP;
        if (push) begin
          wr_ptr  <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + STEP;
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (state == S_DRAIN) begin
          if (discard_next == '0)
            state <= S_RUN;
        end else begin
          state <= S_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule
